// File: rtl/cod7a4_scan.sv
// Multiplexed 7-segment bus readback: per-digit stability filter, segment-to-code
// decode and frame assembly of NDIG digits into a held output frame.
module cod7a4_scan #(
  parameter int unsigned NDIG    = 4,
  parameter int unsigned ESTABLE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        segmentos,
  input  logic [NDIG-1:0]   anodos,
  output logic [4*NDIG-1:0] digitos,
  output logic [NDIG-1:0]   errores,
  output logic [NDIG-1:0]   blancos,
  output logic              frame_valido,
  output logic              ocupado
);

  localparam int unsigned CntW = $clog2(ESTABLE + 1);
  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(ESTABLE - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(ESTABLE);
  localparam logic [NDIG-1:0] AnOne   = {{(NDIG-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StEspera,
    StContando,
    StCapturado
  } state_e;

  // Input sample S and previous sample P
  logic [6:0]      s_seg_q, p_seg_q;
  logic [NDIG-1:0] s_an_q, p_an_q;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Working slots of the frame being assembled
  logic [4*NDIG-1:0] slot_dig_q, slot_dig_d;
  logic [NDIG-1:0]   slot_err_q, slot_err_d;
  logic [NDIG-1:0]   slot_blk_q, slot_blk_d;
  logic [NDIG-1:0]   mask_q, mask_d;

  // Published frame
  logic [4*NDIG-1:0] dig_q, dig_d;
  logic [NDIG-1:0]   err_q, err_d;
  logic [NDIG-1:0]   blk_q, blk_d;
  logic              valido_q;
  logic              ocupado_q;

  logic            s_onehot;
  logic            s_same;
  logic [IdxW-1:0] s_idx;
  logic [3:0]      dec_code;
  logic            dec_err;
  logic            dec_blk;
  logic            capture;
  logic            frame_done;

  // Register the bus every cycle; P trails S by one sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_seg_q <= '0;
      s_an_q  <= '0;
      p_seg_q <= '0;
      p_an_q  <= '0;
    end else begin
      s_seg_q <= segmentos;
      s_an_q  <= anodos;
      p_seg_q <= s_seg_q;
      p_an_q  <= s_an_q;
    end
  end

  assign s_onehot = (s_an_q != '0) && ((s_an_q & (s_an_q - AnOne)) == '0);
  assign s_same   = (s_seg_q == p_seg_q) && (s_an_q == p_an_q);

  // Binary index of the active anode (only meaningful when one-hot)
  always_comb begin
    s_idx = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (s_an_q[i]) s_idx = IdxW'(i);
    end
  end

  // Segment pattern back to 4-bit code; blank and unknown get reserved codes
  always_comb begin
    dec_code = 4'hE;
    dec_err  = 1'b0;
    dec_blk  = 1'b0;
    case (s_seg_q)
      7'b0011010: dec_code = 4'h0;
      7'b0011011: dec_code = 4'h1;
      7'b1011010: dec_code = 4'h2;
      7'b1100010: dec_code = 4'h3;
      7'b1001001: dec_code = 4'h4;
      7'b0011111: dec_code = 4'h5;
      7'b1110001: dec_code = 4'h6;
      7'b1000111: dec_code = 4'h7;
      7'b1110011: dec_code = 4'h8;
      7'b1111111: dec_code = 4'h9;
      7'b0000000: begin
        dec_code = 4'hF;
        dec_blk  = 1'b1;
      end
      default: begin
        dec_code = 4'hE;
        dec_err  = 1'b1;
      end
    endcase
  end

  // Stability FSM state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEspera;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count identical one-hot samples, capture when the count reaches ESTABLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StEspera: begin
        if (s_onehot) begin
          state_d = StContando;
          cnt_d   = CntOne;
        end
      end
      StContando: begin
        if (!s_same || !s_onehot) begin
          if (s_onehot) begin
            cnt_d = CntOne;
          end else begin
            state_d = StEspera;
            cnt_d   = '0;
          end
        end else if (cnt_q < CntMax) begin
          cnt_d = cnt_q + CntOne;
          if (cnt_q == CntLast) begin
            capture = 1'b1;
            state_d = StCapturado;
          end
        end
      end
      StCapturado: begin
        // Counter stays saturated until the bus changes
        if (!s_same) begin
          if (s_onehot) begin
            state_d = StContando;
            cnt_d   = CntOne;
          end else begin
            state_d = StEspera;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = StEspera;
        cnt_d   = '0;
      end
    endcase
  end

  // Slot write, mask update and frame completion (includes the digit captured this edge)
  always_comb begin
    slot_dig_d = slot_dig_q;
    slot_err_d = slot_err_q;
    slot_blk_d = slot_blk_q;
    mask_d     = mask_q;
    dig_d      = dig_q;
    err_d      = err_q;
    blk_d      = blk_q;
    frame_done = 1'b0;
    if (capture) begin
      slot_dig_d[4*s_idx +: 4] = dec_code;
      slot_err_d[s_idx]        = dec_err;
      slot_blk_d[s_idx]        = dec_blk;
      mask_d                   = mask_q | s_an_q;
      if (&mask_d) begin
        frame_done = 1'b1;
        dig_d      = slot_dig_d;
        err_d      = slot_err_d;
        blk_d      = slot_blk_d;
        mask_d     = '0;
      end
    end
  end

  // Working slots, mask and published frame registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_dig_q <= '0;
      slot_err_q <= '0;
      slot_blk_q <= '0;
      mask_q     <= '0;
      dig_q      <= '0;
      err_q      <= '0;
      blk_q      <= '0;
      valido_q   <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      slot_dig_q <= slot_dig_d;
      slot_err_q <= slot_err_d;
      slot_blk_q <= slot_blk_d;
      mask_q     <= mask_d;
      dig_q      <= dig_d;
      err_q      <= err_d;
      blk_q      <= blk_d;
      valido_q   <= frame_done;
      ocupado_q  <= (mask_d != '0);
    end
  end

  assign digitos      = dig_q;
  assign errores      = err_q;
  assign blancos      = blk_q;
  assign frame_valido = valido_q;
  assign ocupado      = ocupado_q;

endmodule

// File: tb/tb_cod7a4_scan.sv
// Randomized + directed bench for cod7a4_scan with a run-length reference model
// and a frame scoreboard checked by an independent monitor.
module tb_cod7a4_scan;

  localparam int unsigned NDIG    = 4;
  localparam int unsigned ESTABLE = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [6:0]        segmentos;
  logic [NDIG-1:0]   anodos;
  logic [4*NDIG-1:0] digitos;
  logic [NDIG-1:0]   errores;
  logic [NDIG-1:0]   blancos;
  logic              frame_valido;
  logic              ocupado;

  cod7a4_scan #(
    .NDIG   (NDIG),
    .ESTABLE(ESTABLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .segmentos   (segmentos),
    .anodos      (anodos),
    .digitos     (digitos),
    .errores     (errores),
    .blancos     (blancos),
    .frame_valido(frame_valido),
    .ocupado     (ocupado)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int frames_seen = 0;

  logic [6:0] pat [10] = '{7'b0011010, 7'b0011011, 7'b1011010, 7'b1100010, 7'b1001001,
                           7'b0011111, 7'b1110001, 7'b1000111, 7'b1110011, 7'b1111111};

  typedef struct {
    int unsigned       at_edge;
    logic [4*NDIG-1:0] dig;
    logic [NDIG-1:0]   err;
    logic [NDIG-1:0]   blk;
  } frame_t;

  frame_t exp_q[$];

  // Reference model state: current run of identical samples and frame slots
  logic [6:0]        run_seg;
  logic [NDIG-1:0]   run_an;
  int                run_len;
  logic [3:0]        m_code [NDIG];
  logic              m_err  [NDIG];
  logic              m_blk  [NDIG];
  logic [NDIG-1:0]   m_mask;
  logic [4*NDIG-1:0] m_last_dig;
  logic [NDIG-1:0]   m_last_err;
  logic [NDIG-1:0]   m_last_blk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    run_seg = '0;
    run_an  = '0;
    run_len = 0;
    m_mask  = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      m_code[i] = '0;
      m_err[i]  = 1'b0;
      m_blk[i]  = 1'b0;
    end
    m_last_dig = '0;
    m_last_err = '0;
    m_last_blk = '0;
    exp_q.delete();
  endfunction

  // One sampled value per clock edge; a one-hot run reaching ESTABLE samples is captured
  function automatic void model_step(input logic [6:0] seg, input logic [NDIG-1:0] an,
                                     input int unsigned edge_now);
    int     k;
    logic [3:0] code;
    logic   e;
    logic   b;
    frame_t f;
    if (seg == run_seg && an == run_an) begin
      run_len++;
    end else begin
      run_seg = seg;
      run_an  = an;
      run_len = 1;
    end
    if (run_len == int'(ESTABLE) && $countones(an) == 1) begin
      k = 0;
      for (int i = 0; i < int'(NDIG); i++) if (an[i]) k = i;
      code = 4'hE;
      e    = 1'b1;
      b    = 1'b0;
      if (seg == 7'b0000000) begin
        code = 4'hF;
        e    = 1'b0;
        b    = 1'b1;
      end else begin
        for (int v = 0; v < 10; v++) begin
          if (pat[v] == seg) begin
            code = 4'(v);
            e    = 1'b0;
          end
        end
      end
      m_code[k] = code;
      m_err[k]  = e;
      m_blk[k]  = b;
      m_mask[k] = 1'b1;
      if (&m_mask) begin
        f.at_edge = edge_now + 1;
        for (int i = 0; i < int'(NDIG); i++) begin
          f.dig[4*i +: 4] = m_code[i];
          f.err[i]        = m_err[i];
          f.blk[i]        = m_blk[i];
        end
        exp_q.push_back(f);
        m_last_dig = f.dig;
        m_last_err = f.err;
        m_last_blk = f.blk;
        m_mask     = '0;
      end
    end
  endfunction

  task automatic drive(input logic [6:0] seg, input logic [NDIG-1:0] an, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      segmentos = seg;
      anodos    = an;
      @(posedge clk);
      #1;
      model_step(seg, an, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    segmentos = '0;
    anodos    = '0;
    rst       = 1'b1;
    #1;
    check("rst_digitos", 32'(digitos), 32'h0);
    check("rst_errores", 32'(errores), 32'h0);
    check("rst_blancos", 32'(blancos), 32'h0);
    check("rst_ocupado", 32'(ocupado), 32'h0);
    check("rst_frame_valido", 32'(frame_valido), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: every frame_valido pulse must match the next expected frame and edge
  always @(negedge clk) begin
    frame_t f;
    if (rst === 1'b0 && frame_valido === 1'b1) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: got digitos=%0h with no frame expected (cyc=%0d)",
                 digitos, cyc);
      end else begin
        f = exp_q.pop_front();
        check("frame_edge", cyc, f.at_edge);
        check("frame_digitos", 32'(digitos), 32'(f.dig));
        check("frame_errores", 32'(errores), 32'(f.err));
        check("frame_blancos", 32'(blancos), 32'(f.blk));
      end
    end
  end

  initial begin
    int f0;
    logic [NDIG-1:0] an;
    logic [6:0]      seg;
    rst       = 1'b1;
    segmentos = '0;
    anodos    = '0;
    model_reset();
    do_reset();

    // 3,1,4,1 with a short glitch of 3 in slot 1
    f0 = frames_seen;
    drive(pat[3], 4'b0001, 20);
    check("ocupado_partial", 32'(ocupado), 32'h1);
    drive(pat[3], 4'b0010, 5);
    drive(pat[1], 4'b0010, 20);
    drive(pat[4], 4'b0100, 20);
    drive(pat[1], 4'b1000, 20);
    check("f1_digitos", 32'(digitos), 32'h1413);
    check("f1_errores", 32'(errores), 32'h0);
    check("f1_blancos", 32'(blancos), 32'h0);
    check("f1_ocupado_after", 32'(ocupado), 32'h0);
    check("f1_pulses", 32'(frames_seen - f0), 32'h1);

    // Unknown pattern and blank
    drive(pat[9], 4'b0001, 20);
    drive(pat[9], 4'b0010, 20);
    drive(7'b1111110, 4'b0100, 20);
    drive(7'b0000000, 4'b1000, 20);
    check("f2_digitos", 32'(digitos), 32'hFE99);
    check("f2_errores", 32'(errores), 32'b0100);
    check("f2_blancos", 32'(blancos), 32'b1000);

    // Illegal anodes leave the partial frame alone, then overwrite of slot 0
    f0 = frames_seen;
    drive(pat[5], 4'b0001, 20);
    drive(pat[8], 4'b0011, 50);
    drive(pat[8], 4'b0000, 50);
    check("illegal_ocupado", 32'(ocupado), 32'h1);
    check("illegal_no_frame", 32'(frames_seen - f0), 32'h0);
    drive(pat[7], 4'b0001, 20);
    drive(pat[0], 4'b0010, 20);
    drive(pat[0], 4'b0100, 20);
    drive(pat[0], 4'b1000, 20);
    check("f3_digitos", 32'(digitos), 32'h0007);
    check("f3_pulses", 32'(frames_seen - f0), 32'h1);

    // Reset mid-frame, then a clean 2,2,2,2 frame
    drive(pat[2], 4'b0001, 20);
    drive(pat[2], 4'b0010, 20);
    check("pre_rst_ocupado", 32'(ocupado), 32'h1);
    do_reset();
    f0 = frames_seen;
    for (int i = 0; i < int'(NDIG); i++) drive(pat[2], NDIG'(1) << i, 20);
    check("f4_digitos", 32'(digitos), 32'h2222);
    check("f4_pulses", 32'(frames_seen - f0), 32'h1);

    // Randomized bus traffic against the run-length model
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 8) an = NDIG'(1) << $urandom_range(0, NDIG - 1);
      else an = NDIG'($urandom_range(0, (1 << NDIG) - 1));
      case ($urandom_range(0, 9))
        0:       seg = 7'b0000000;
        1, 2, 3: seg = 7'($urandom_range(0, 127));
        default: seg = pat[$urandom_range(0, 9)];
      endcase
      drive(seg, an, int'($urandom_range(1, 20)));
    end
    drive(7'b0000000, 4'b0000, int'(ESTABLE) + 4);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("final_digitos", 32'(digitos), 32'(m_last_dig));
    check("final_errores", 32'(errores), 32'(m_last_err));
    check("final_blancos", 32'(blancos), 32'(m_last_blk));
    check("final_ocupado", 32'(ocupado), 32'(m_mask != '0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
